// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, default NOP word, the skid
// buffer state encoding and the opcode/funct values the detector accepts.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

  // Occupancy of the 2-entry skid buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  // Primary opcodes (instr[31:26]) of the supported MIPS-I integer subset.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  // SPECIAL funct codes (instr[5:0]) that are supported.
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/instruction_detector.sv
// Combinational classifier: flags whether one instruction word belongs to
// the supported MIPS-I integer subset. Only opcode and funct fields matter.
module instruction_detector
  import cpu_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output logic       o_supported
);

  // Decode opcode, and funct for SPECIAL, against the supported list.
  always_comb begin
    // NOTE: default assignment up front so every path drives the output and no latch is inferred.
    o_supported = 1'b0;
    case (i_opcode)
      OP_SPECIAL: begin
        case (i_funct)
          FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: o_supported = 1'b1;
          default:                                         o_supported = 1'b0;
        endcase
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: o_supported = 1'b1;
      default:                                        o_supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_filter.sv
// Instruction filter: replaces unsupported instruction lanes with NOP_WORD,
// flags them on out_illegal and buffers beats in a 2-entry skid buffer with
// fully registered handshake outputs.
// Optional feature: define INSTRUCTION_FILTER_COUNT_EN to build the
// saturating squash counter; otherwise squash_count is tied to zero.
module instruction_filter
  import cpu_pkg::*;
#(
  parameter int                 LANES    = 1,
  parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT,
  parameter int                 CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W*LANES-1:0] in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W*LANES-1:0] out_instr,
  output logic [LANES-1:0]         out_illegal,
  output logic [CNT_W-1:0]         squash_count
);

  logic [LANES-1:0]         w_supported;
  logic [INSTR_W*LANES-1:0] w_filt_instr;
  logic [LANES-1:0]         w_filt_illegal;
  logic                     w_in_fire;
  logic                     w_out_fire;

  skid_state_t              r_state;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic [INSTR_W*LANES-1:0] r_head_instr;
  logic [LANES-1:0]         r_head_illegal;
  logic [INSTR_W*LANES-1:0] r_skid_instr;
  logic [LANES-1:0]         r_skid_illegal;

  // One detector per lane; unsupported lanes become NOP_WORD.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    instruction_detector u_detector (
      .i_opcode    (in_instr[g*INSTR_W+26 +: 6]),
      .i_funct     (in_instr[g*INSTR_W    +: 6]),
      .o_supported (w_supported[g])
    );
    assign w_filt_instr[g*INSTR_W +: INSTR_W] =
      w_supported[g] ? in_instr[g*INSTR_W +: INSTR_W] : NOP_WORD;
    assign w_filt_illegal[g] = ~w_supported[g];
  end

  assign w_in_fire  = in_valid  && r_in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Skid FSM with registered in_ready/out_valid and head entry; flush wins.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      r_state        <= EMPTY;
      r_in_ready     <= 1'b0;
      r_out_valid    <= 1'b0;
      r_head_instr   <= '0;
      r_head_illegal <= '0;
    end else if (flush) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        EMPTY: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_head_instr   <= w_filt_instr;
            r_head_illegal <= w_filt_illegal;
            r_out_valid    <= 1'b1;
            r_state        <= ONE;
          end
        end
        ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_head_instr   <= w_filt_instr;
            r_head_illegal <= w_filt_illegal;
          end else if (w_in_fire) begin
            r_in_ready <= 1'b0;
            r_state    <= TWO;
          end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_state     <= EMPTY;
          end
        end
        TWO: begin
          if (w_out_fire) begin
            r_head_instr   <= r_skid_instr;
            r_head_illegal <= r_skid_illegal;
            r_in_ready     <= 1'b1;
            r_state        <= ONE;
          end
        end
        default: begin
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_state     <= EMPTY;
        end
      endcase
    end
  end

  // Skid entry captures every accepted beat; it is only read in state TWO.
  always_ff @(posedge clk) begin
    // NOTE: buffer storage is deliberately not reset; state alone decides whether it holds a live beat.
    if (w_in_fire) begin
      r_skid_instr   <= w_filt_instr;
      r_skid_illegal <= w_filt_illegal;
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_head_instr;
  assign out_illegal = r_head_illegal;

`ifdef INSTRUCTION_FILTER_COUNT_EN
  logic [CNT_W-1:0] r_squash_count;
  logic [2:0]       w_pop;
  logic [CNT_W:0]   w_sum;

  // Population count of unsupported lanes in the offered beat.
  always_comb begin
    w_pop = '0;
    for (int l = 0; l < LANES; l++) begin
      w_pop = w_pop + {2'b00, w_filt_illegal[l]};
    end
  end

  assign w_sum = {1'b0, r_squash_count} + {{(CNT_W-2){1'b0}}, w_pop};

  // Saturating squash counter, advanced on every input transfer (even flushed ones).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_squash_count <= '0;
    end else if (w_in_fire) begin
      r_squash_count <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign squash_count = r_squash_count;
`else
  assign squash_count = '0;
`endif

endmodule

// File: tb/tb_instruction_filter.sv
// Self-checking bench for instruction_filter: a LANES=1 instance and a
// LANES=2/CNT_W=4 instance, driven one at a time against a queue-based
// reference model plus directed spot checks.
module tb_instruction_filter;

`ifdef INSTRUCTION_FILTER_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  // Instance 0: LANES=1
  logic        f1, v1, or1;
  logic [31:0] i1;
  logic        ir1, ov1;
  logic [31:0] oi1;
  logic [0:0]  ol1;
  logic [15:0] sc1;

  // Instance 1: LANES=2, CNT_W=4
  logic        f2, v2, or2;
  logic [63:0] i2;
  logic        ir2, ov2;
  logic [63:0] oi2;
  logic [1:0]  ol2;
  logic [3:0]  sc2;

  instruction_filter #(.LANES(1), .CNT_W(16)) u_l1 (
    .clk(clk), .reset(reset), .flush(f1),
    .in_valid(v1), .in_ready(ir1), .in_instr(i1),
    .out_valid(ov1), .out_ready(or1), .out_instr(oi1),
    .out_illegal(ol1), .squash_count(sc1)
  );

  instruction_filter #(.LANES(2), .CNT_W(4)) u_l2 (
    .clk(clk), .reset(reset), .flush(f2),
    .in_valid(v2), .in_ready(ir2), .in_instr(i2),
    .out_valid(ov2), .out_ready(or2), .out_instr(oi2),
    .out_illegal(ol2), .squash_count(sc2)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] instr;
    logic [1:0]  ill;
  } beat_t;

  // Supported subset from the MIPS-I opcode / SPECIAL funct tables (decimal).
  int sup_ops [14] = '{2, 3, 4, 5, 8, 9, 10, 11, 12, 13, 14, 15, 35, 43};
  int sup_fn  [15] = '{0, 2, 3, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};

  beat_t q[$];
  int    sel;
  int    m_lanes;
  int    m_cnt;
  int    m_cnt_max;
  bit    m_live;
  int    n_cmp = 0;
  int    n_bad = 0;

  logic        obs_ready, obs_valid;
  logic [63:0] obs_instr;
  logic [1:0]  obs_ill;
  logic [15:0] obs_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_supported(input logic [31:0] w);
    int op, fn;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    if (op == 0) begin
      foreach (sup_fn[k]) if (sup_fn[k] == fn) return 1'b1;
      return 1'b0;
    end
    foreach (sup_ops[k]) if (sup_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic beat_t ref_filter(input logic [63:0] w);
    beat_t b;
    logic [31:0] word;
    b.instr = '0;
    b.ill   = '0;
    for (int l = 0; l < m_lanes; l++) begin
      word = w[32*l +: 32];
      if (ref_supported(word)) b.instr[32*l +: 32] = word;
      else begin
        b.instr[32*l +: 32] = 32'h0000_0000;
        b.ill[l] = 1'b1;
      end
    end
    return b;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: ;
      1: r[31:26] = 6'(sup_ops[$urandom_range(0, 13)]);
      2: begin
        r[31:26] = 6'd0;
        r[5:0]   = 6'(sup_fn[$urandom_range(0, 14)]);
      end
      default: r[31:26] = 6'd0;
    endcase
    return r;
  endfunction

  task automatic sample();
    if (sel == 0) begin
      obs_ready = ir1;  obs_valid = ov1;
      obs_instr = {32'h0, oi1}; obs_ill = {1'b0, ol1}; obs_cnt = sc1;
    end else begin
      obs_ready = ir2;  obs_valid = ov2;
      obs_instr = oi2;  obs_ill = ol2; obs_cnt = {12'h0, sc2};
    end
  endtask

  task automatic drive(input bit v, input logic [63:0] w, input bit ordy, input bit fl);
    if (sel == 0) begin
      v1 = v; i1 = w[31:0]; or1 = ordy; f1 = fl;
      v2 = 1'b0; i2 = '0; or2 = 1'b0; f2 = 1'b0;
    end else begin
      v2 = v; i2 = w; or2 = ordy; f2 = fl;
      v1 = 1'b0; i1 = '0; or1 = 1'b0; f1 = 1'b0;
    end
  endtask

  // One clock cycle: compare outputs with the model, drive, clock, advance model.
  // Entered and left at a falling edge.
  task automatic step(input bit v, input logic [63:0] w, input bit ordy, input bit fl);
    bit    e_rdy, e_vld;
    beat_t b;
    int    pc;
    e_rdy = m_live && (q.size() < 2);
    e_vld = (q.size() > 0);
    sample();
    check("in_ready", obs_ready, e_rdy);
    check("out_valid", obs_valid, e_vld);
    if (e_vld) begin
      check("out_instr", obs_instr, q[0].instr);
      check("out_illegal", obs_ill, q[0].ill);
    end
    check("squash_count", obs_cnt, COUNT_EN ? m_cnt : 0);
    drive(v, w, ordy, fl);
    @(posedge clk);
    b = ref_filter(w);
    if (v && e_rdy) begin
      pc = $countones(b.ill);
      m_cnt = (m_cnt + pc > m_cnt_max) ? m_cnt_max : m_cnt + pc;
    end
    if (fl) q.delete();
    else begin
      if (e_vld && ordy) void'(q.pop_front());
      if (v && e_rdy) q.push_back(b);
    end
    m_live = 1'b1;
    @(negedge clk);
  endtask

  // Assert reset between edges, check outputs clear at once, release at a falling edge.
  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_ready_l1", ir1, 0);
    check("rst_valid_l1", ov1, 0);
    check("rst_instr_l1", oi1, 0);
    check("rst_ill_l1", ol1, 0);
    check("rst_cnt_l1", sc1, 0);
    check("rst_ready_l2", ir2, 0);
    check("rst_valid_l2", ov2, 0);
    check("rst_instr_l2", oi2, 0);
    check("rst_ill_l2", ol2, 0);
    check("rst_cnt_l2", sc2, 0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b1;
    q.delete();
    m_cnt  = 0;
    m_live = 1'b0;
  endtask

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      step($urandom_range(0, 9) < 7, {rand_word(), rand_word()},
           $urandom_range(0, 9) < 6, $urandom_range(0, 31) == 0);
    end
  endtask

  localparam logic [31:0] A = 32'h0022_1821;  // addu
  localparam logic [31:0] B = 32'h8C22_0004;  // lw
  localparam logic [31:0] C = 32'hAC22_0008;  // sw

  initial begin
    sel = 0; m_lanes = 1; m_cnt_max = 65535; m_cnt = 0; m_live = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // First cycle after release: in_ready rises, nothing buffered.
    step(1'b0, '0, 1'b1, 1'b0);
    sample();
    check("ready_after_release", obs_ready, 1);

    // Single supported lane passes through with one cycle latency.
    step(1'b1, {32'h0, 32'h0000_0021}, 1'b1, 1'b0);
    sample();
    check("addu_valid", obs_valid, 1);
    check("addu_instr", obs_instr, 64'h0000_0021);
    check("addu_illegal", obs_ill, 0);
    check("addu_count", obs_cnt, 0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A,B accepted, C refused, then all three drain in order.
    step(1'b1, {32'h0, A}, 1'b0, 1'b0);
    step(1'b1, {32'h0, B}, 1'b0, 1'b0);
    sample();
    check("bp_c_refused", obs_ready, 0);
    check("bp_head_a", obs_instr, {32'h0, A});
    step(1'b1, {32'h0, C}, 1'b0, 1'b0);
    step(1'b1, {32'h0, C}, 1'b1, 1'b0);
    sample();
    check("bp_head_b", obs_instr, {32'h0, B});
    step(1'b1, {32'h0, C}, 1'b1, 1'b0);
    sample();
    check("bp_head_c", obs_instr, {32'h0, C});
    step(1'b0, '0, 1'b1, 1'b0);
    sample();
    check("bp_drained", obs_valid, 0);

    // Flush in state TWO with out_ready high empties the buffer.
    step(1'b1, {32'h0, A}, 1'b0, 1'b0);
    step(1'b1, {32'h0, B}, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    sample();
    check("flush_valid", obs_valid, 0);
    check("flush_ready", obs_ready, 1);
    // Flush discards an offered unsupported beat but still counts it.
    step(1'b1, {32'h0, 32'hFC00_0000}, 1'b1, 1'b1);
    sample();
    check("flush_disc_valid", obs_valid, 0);
    check("flush_disc_count", obs_cnt, COUNT_EN ? 1 : 0);

    // Reset mid-stream, then a fresh beat returns with one cycle latency.
    step(1'b1, {32'h0, A}, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, {32'h0, B}, 1'b1, 1'b0);
    sample();
    check("post_rst_valid", obs_valid, 1);
    check("post_rst_instr", obs_instr, {32'h0, B});

    random_run(400);

    // -------- LANES=2, CNT_W=4 instance --------
    sel = 1; m_lanes = 2; m_cnt_max = 15;
    drive(1'b0, '0, 1'b0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, {32'hFC00_0000, 32'h3C01_1234}, 1'b1, 1'b0);
    sample();
    check("l2_instr", obs_instr, {32'h0000_0000, 32'h3C01_1234});
    check("l2_illegal", obs_ill, 2'b10);
    check("l2_count", obs_cnt, COUNT_EN ? 1 : 0);

    for (int k = 0; k < 20; k++) step(1'b1, {32'hFC00_0000, 32'hFFFF_FFFF}, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    sample();
    check("sat_count", obs_cnt, COUNT_EN ? 15 : 0);

    do_reset();
    random_run(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
